// File: rtl/ewma_alarm_fsm_pkg.sv
// Shared types and defaults for the EWMA jamming-alarm decision stage.
// Limits are in dBm, two's complement.
package ewma_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PENDING = 2'd1,
        ALERT   = 2'd2,
        RECOVER = 2'd3
    } alarm_state_e;

    localparam int signed UCL_DEF = -65;
    localparam int signed LCL_DEF = -106;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ewma_alarm_fsm_if.sv
// Sample, limit-configuration and alarm-status bundle between the EWMA filter/CPU side and the alarm FSM.
// master drives samples and limits; slave is the alarm stage.
interface ewma_alarm_fsm_if #(
    parameter int WIDTH = 32,
    parameter int EVT_W = 16
);
    logic             sample_valid;
    logic [WIDTH-1:0] ewma_rssi;
    logic [WIDTH-1:0] ucl;
    logic [WIDTH-1:0] lcl;
    logic             lcl_en;
    logic             clr_events;
    logic             alert;
    logic             alert_high;
    logic             alert_low;
    logic             event_pulse;
    logic [EVT_W-1:0] event_count;
    logic [1:0]       state;

    modport master (
        output sample_valid, ewma_rssi, ucl, lcl, lcl_en, clr_events,
        input  alert, alert_high, alert_low, event_pulse, event_count, state
    );

    modport slave (
        input  sample_valid, ewma_rssi, ucl, lcl, lcl_en, clr_events,
        output alert, alert_high, alert_low, event_pulse, event_count, state
    );
endinterface

// File: rtl/ewma_alarm_fsm_run_counter.sv
// Clearable, loadable up-counter; hit_next flags that the next increment lands on term.
// Used for both the assert and clear debounce runs.
module ewma_run_counter #(
    parameter int W = 4
) (
    input  logic         clk_h,
    input  logic         rst_h,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic         hit_next
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit_next = ((cnt + W'(1)) == term);

endmodule

// File: rtl/ewma_alarm_fsm.sv
// Debounced jamming alarm: signed limit check on filtered RSSI, assert/clear run-lengths,
// registered cause flags, rising-edge pulse and saturating event counter.
module ewma_alarm_fsm
    import ewma_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ASSERT_CNT = 4,
    parameter int CLEAR_CNT  = 8,
    parameter int EVT_W      = 16
) (
    input logic              clk_h,
    input logic              rst_h,
    ewma_alarm_fsm_if.slave  bus
);
    localparam int RUN_W = $clog2(max_int(ASSERT_CNT, CLEAR_CNT) + 1);

    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (&v) ? v : v + EVT_W'(1);
    endfunction

    // Stage p0: signed limit comparison of the incoming sample
    logic signed [WIDTH-1:0] rssi_p0, ucl_p0, lcl_p0;
    logic                    vld_p0, high_p0, low_p0, out_p0;

    assign vld_p0  = bus.sample_valid;
    assign rssi_p0 = bus.ewma_rssi;
    assign ucl_p0  = bus.ucl;
    assign lcl_p0  = bus.lcl;
    assign high_p0 = (rssi_p0 > ucl_p0);
    assign low_p0  = bus.lcl_en && (rssi_p0 < lcl_p0);
    assign out_p0  = high_p0 || low_p0;

    alarm_state_e     state_q, state_d;
    logic             run_clr, run_load, run_inc, run_hit;
    logic             enter_alert;
    logic [RUN_W-1:0] run_term;

    assign run_term = (state_q == PENDING) ? RUN_W'(ASSERT_CNT) : RUN_W'(CLEAR_CNT);

    ewma_run_counter #(.W(RUN_W)) u_run (
        .clk_h    (clk_h),
        .rst_h    (rst_h),
        .clr      (run_clr),
        .load     (run_load),
        .inc      (run_inc),
        .load_val (RUN_W'(1)),
        .term     (run_term),
        .hit_next (run_hit)
    );

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_clr     = 1'b0;
        run_load    = 1'b0;
        run_inc     = 1'b0;
        enter_alert = 1'b0;
        if (vld_p0) begin
            unique case (state_q)
                NORMAL: begin
                    if (out_p0) begin
                        run_load = 1'b1;
                        if (ASSERT_CNT == 1) begin
                            state_d     = ALERT;
                            enter_alert = 1'b1;
                        end else begin
                            state_d = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (out_p0) begin
                        run_inc = 1'b1;
                        if (run_hit) begin
                            state_d     = ALERT;
                            enter_alert = 1'b1;
                        end
                    end else begin
                        run_clr = 1'b1;
                        state_d = NORMAL;
                    end
                end
                ALERT: begin
                    if (!out_p0) begin
                        run_load = 1'b1;
                        state_d  = (CLEAR_CNT == 1) ? NORMAL : RECOVER;
                    end
                end
                RECOVER: begin
                    if (out_p0) begin
                        run_clr = 1'b1;
                        state_d = ALERT;
                    end else begin
                        run_inc = 1'b1;
                        if (run_hit) begin
                            state_d = NORMAL;
                        end
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    // Stage p1: registered alarm outputs
    logic             alert_p1, high_p1, low_p1, pulse_p1;
    logic [EVT_W-1:0] count_p1;

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            alert_p1 <= 1'b0;
            high_p1  <= 1'b0;
            low_p1   <= 1'b0;
            pulse_p1 <= 1'b0;
            count_p1 <= '0;
        end else begin
            pulse_p1 <= enter_alert;
            if (vld_p0) begin
                alert_p1 <= (state_d == ALERT) || (state_d == RECOVER);
                if (state_d == NORMAL) begin
                    high_p1 <= 1'b0;
                    low_p1  <= 1'b0;
                end else if ((state_d == ALERT) && out_p0) begin
                    high_p1 <= high_p0;
                    low_p1  <= low_p0;
                end
            end
            // Clear has priority over a coincident increment
            if (bus.clr_events) begin
                count_p1 <= '0;
            end else if (enter_alert) begin
                count_p1 <= sat_inc(count_p1);
            end
        end
    end

    assign bus.alert       = alert_p1;
    assign bus.alert_high  = high_p1;
    assign bus.alert_low   = low_p1;
    assign bus.event_pulse = pulse_p1;
    assign bus.event_count = count_p1;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_ewma_alarm_fsm.sv
// Scoreboard bench for ewma_alarm_fsm: directed samples push hand-computed results,
// a monitor pops and compares one cycle after each valid sample.
module tb_ewma_alarm_fsm;
    import ewma_pkg::*;

    localparam int WIDTH = 32;
    localparam int EVT_W = 2;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       al;
        logic       hi;
        logic       lo;
        logic       pu;
        logic [1:0] cnt;
    } exp_t;

    logic clk_h = 1'b0;
    logic rst_h = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ewma_alarm_fsm_if #(.WIDTH(WIDTH), .EVT_W(EVT_W)) bus ();

    ewma_alarm_fsm #(
        .WIDTH(WIDTH), .ASSERT_CNT(4), .CLEAR_CNT(8), .EVT_W(EVT_W)
    ) dut (
        .clk_h (clk_h),
        .rst_h (rst_h),
        .bus   (bus)
    );

    always #5 clk_h = ~clk_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk_h) begin
        if (rst_h && bus.sample_valid) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.tag, ".state"}, 32'(bus.state), 32'(mon_e.st));
                chk({mon_e.tag, ".alert"}, 32'(bus.alert), 32'(mon_e.al));
                chk({mon_e.tag, ".high"},  32'(bus.alert_high), 32'(mon_e.hi));
                chk({mon_e.tag, ".low"},   32'(bus.alert_low), 32'(mon_e.lo));
                chk({mon_e.tag, ".pulse"}, 32'(bus.event_pulse), 32'(mon_e.pu));
                chk({mon_e.tag, ".count"}, 32'(bus.event_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic send(input int rssi, input logic clr, input logic [1:0] st, input logic al,
                        input logic hi, input logic lo, input logic pu, input logic [1:0] cnt,
                        input string tag);
        exp_t e;
        @(negedge clk_h);
        bus.sample_valid = 1'b1;
        bus.ewma_rssi    = rssi;
        bus.clr_events   = clr;
        e.tag = tag; e.st = st; e.al = al; e.hi = hi; e.lo = lo; e.pu = pu; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_h);
            bus.sample_valid = 1'b0;
            bus.clr_events   = 1'b0;
            bus.ewma_rssi    = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.ewma_rssi    = '0;
        bus.ucl          = UCL_DEF;
        bus.lcl          = LCL_DEF;
        bus.lcl_en       = 1'b0;
        bus.clr_events   = 1'b0;
        #23;
        chk("reset.state", 32'(bus.state), 0);
        chk("reset.alert", 32'(bus.alert), 0);
        chk("reset.count", 32'(bus.event_count), 0);
        chk("reset.pulse", 32'(bus.event_pulse), 0);
        rst_h = 1'b1;

        // Four -60 samples above ucl raise the alert
        for (int i = 0; i < 3; i++) send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd0, "assert_pend");
        send(-60, 0, 2'd2, 1, 1, 0, 1, 2'd1, "assert_hit");
        idle(2);
        chk("pulse_single", 32'(bus.event_pulse), 0);
        chk("alert_hold_idle", 32'(bus.alert), 1);

        // Recovery broken by one out sample, then full clear
        for (int i = 0; i < 7; i++) send(-80, 0, 2'd3, 1, 1, 0, 0, 2'd1, "recover_run");
        send(-60, 0, 2'd2, 1, 1, 0, 0, 2'd1, "recover_break");
        for (int i = 0; i < 7; i++) send(-80, 0, 2'd3, 1, 1, 0, 0, 2'd1, "recover_run2");
        send(-80, 0, 2'd0, 0, 0, 0, 0, 2'd1, "recover_done");

        // Broken run with idle gaps; wild samples ignored while not valid
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd1, "brk1");
        idle(3);
        chk("idle_hold_state", 32'(bus.state), 1);
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd1, "brk2");
        send(-80, 0, 2'd0, 0, 0, 0, 0, 2'd1, "brk_in");
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd1, "brk3");
        idle(2);
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd1, "brk4");
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd1, "brk5");
        idle(1);
        send(-60, 0, 2'd2, 1, 1, 0, 1, 2'd2, "brk_hit");
        for (int i = 0; i < 7; i++) send(-80, 0, 2'd3, 1, 1, 0, 0, 2'd2, "clr2_run");
        send(-80, 0, 2'd0, 0, 0, 0, 0, 2'd2, "clr2_done");

        // Lower-limit check
        idle(1);
        bus.lcl_en = 1'b1;
        for (int i = 0; i < 3; i++) send(-110, 0, 2'd1, 0, 0, 0, 0, 2'd2, "low_pend");
        send(-110, 0, 2'd2, 1, 0, 1, 1, 2'd3, "low_hit");
        for (int i = 0; i < 7; i++) send(-80, 0, 2'd3, 1, 0, 1, 0, 2'd3, "low_rec");
        send(-80, 0, 2'd0, 0, 0, 0, 0, 2'd3, "low_done");
        idle(1);
        bus.lcl_en = 1'b0;
        for (int i = 0; i < 4; i++) send(-110, 0, 2'd0, 0, 0, 0, 0, 2'd3, "low_disabled");

        // Saturation, then clear coinciding with an increment
        for (int i = 0; i < 3; i++) send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd3, "sat_pend");
        send(-60, 0, 2'd2, 1, 1, 0, 1, 2'd3, "sat_hit");
        for (int i = 0; i < 7; i++) send(-80, 0, 2'd3, 1, 1, 0, 0, 2'd3, "sat_rec");
        send(-80, 0, 2'd0, 0, 0, 0, 0, 2'd3, "sat_done");
        for (int i = 0; i < 3; i++) send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd3, "clr_pend");
        send(-60, 1, 2'd2, 1, 1, 0, 1, 2'd0, "clr_win");

        // Inverted limits: both causes at once
        idle(1);
        bus.ucl = -120;
        bus.lcl = -50;
        bus.lcl_en = 1'b1;
        send(-80, 0, 2'd2, 1, 1, 1, 0, 2'd0, "inverted");
        idle(1);
        bus.ucl = UCL_DEF;
        bus.lcl = LCL_DEF;
        send(-80, 0, 2'd3, 1, 1, 1, 0, 2'd0, "to_recover");
        idle(1);

        // Asynchronous reset while in RECOVER
        #2 rst_h = 1'b0;
        #1;
        chk("areset.state", 32'(bus.state), 0);
        chk("areset.alert", 32'(bus.alert), 0);
        chk("areset.high", 32'(bus.alert_high), 0);
        chk("areset.low", 32'(bus.alert_low), 0);
        @(negedge clk_h);
        rst_h = 1'b1;
        idle(3);
        chk("post_reset.pulse", 32'(bus.event_pulse), 0);
        chk("post_reset.state", 32'(bus.state), 0);
        send(-60, 0, 2'd1, 0, 0, 0, 0, 2'd0, "post_reset_pend");
        idle(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
